spi_byte_queue: RTL and testbench

Byte queue between the peripheral register interface and the SPI byte controller. Buffers outgoing bytes tagged with data/command and end-of-transaction flags, issues them to the controller one at a time with a correct start/busy handshake, and optionally captures the bytes shifted in by the controller into a receive FIFO. CPU writes do not stall on SPI clocking.

---
 rtl/spi_queue_pkg.sv | 16 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/spi_byte_queue.sv | 161 ++++++++++++++++
 tb/tb_spi_byte_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_queue_pkg.sv
// Shared types for the SPI byte queue: FSM states and TX entry layout.
// Optional RX path is enabled by SPI_BYTE_QUEUE_RX_EN.
package spi_queue_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY
  } state_t;

  localparam int ENTRY_W = 11;
  localparam int CAP_BIT = 10;
  localparam int END_BIT = 9;
  localparam int DC_BIT  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, flush, and level output.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_byte_queue.sv
// TX/RX byte queue feeding an SPI byte controller with start/busy handshake.
// Define SPI_BYTE_QUEUE_RX_EN to build the receive FIFO and capture path.
module spi_byte_queue
  import spi_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  input  logic                   wr_dc,
  input  logic                   wr_end_txn,
  input  logic                   wr_capture,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   idle,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  input  logic                   rx_pop,
  output logic                   rx_overflow,
  input  logic                   clear_overflow,
  output logic                   ctrl_start,
  output logic [7:0]             ctrl_data,
  output logic                   ctrl_dc,
  output logic                   ctrl_end_txn,
  input  logic                   ctrl_busy,
  input  logic [7:0]             ctrl_data_out
);

  state_t state;
  state_t state_n;

  logic               tx_full;
  logic               tx_empty;
  logic               tx_push;
  logic               tx_pop;
  logic               finish;
  logic [ENTRY_W-1:0] tx_wdata;
  logic [ENTRY_W-1:0] tx_rdata;

  assign tx_wdata = {wr_capture, wr_end_txn, wr_dc, wr_data};
  assign tx_push  = wr_valid && !tx_full && !flush;
  assign wr_ready = !tx_full;
  assign idle     = tx_empty && (state == S_IDLE) && !ctrl_busy;

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // A flush in the issue cycle wins: the head is discarded, not sent.
  always_comb begin
    state_n = state;
    tx_pop  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!tx_empty && !ctrl_busy && !flush) begin
          tx_pop  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: state_n = S_BUSY;
      S_BUSY: begin
        if (!ctrl_busy) begin
          finish  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_start   <= 1'b0;
      ctrl_data    <= 8'h00;
      ctrl_dc      <= 1'b0;
      ctrl_end_txn <= 1'b1;
    end else begin
      ctrl_start <= tx_pop;
      if (tx_pop) begin
        ctrl_data    <= tx_rdata[7:0];
        ctrl_dc      <= tx_rdata[DC_BIT];
        ctrl_end_txn <= tx_rdata[END_BIT];
      end
    end
  end

`ifdef SPI_BYTE_QUEUE_RX_EN
  logic                   cap_pend;
  logic                   rx_wr;
  logic [7:0]             rx_wr_data;
  logic                   rx_full;
  logic                   rx_empty;
  logic [7:0]             rx_head;
  logic [$clog2(DEPTH):0] rx_level_unused;

  // Received byte is staged one cycle before entering the RX FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cap_pend    <= 1'b0;
      rx_wr       <= 1'b0;
      rx_wr_data  <= 8'h00;
      rx_overflow <= 1'b0;
    end else begin
      if (tx_pop) cap_pend <= tx_rdata[CAP_BIT];
      rx_wr <= finish && cap_pend;
      if (finish) rx_wr_data <= ctrl_data_out;
      if (rx_wr && rx_full && !rx_pop) rx_overflow <= 1'b1;
      else if (clear_overflow)         rx_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .flush (1'b0),
    .push  (rx_wr),
    .wdata (rx_wr_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level_unused)
  );

  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? 8'h00 : rx_head;
`else
  logic unused_rx;

  assign unused_rx   = ^{tx_rdata[CAP_BIT], rx_pop, clear_overflow,
                         ctrl_data_out, finish};
  assign rx_valid    = 1'b0;
  assign rx_data     = 8'h00;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_queue.sv
// Directed bench for spi_byte_queue with a small SPI controller model.
// RX expectations follow SPI_BYTE_QUEUE_RX_EN.
module tb_spi_byte_queue;

`ifdef SPI_BYTE_QUEUE_RX_EN
  localparam int RX = 1;
`else
  localparam int RX = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_dc;
  logic       wr_end_txn;
  logic       wr_capture;
  logic       wr_ready;
  logic       flush;
  logic [2:0] tx_level;
  logic       idle;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       rx_overflow;
  logic       clear_overflow;
  logic       ctrl_start;
  logic [7:0] ctrl_data;
  logic       ctrl_dc;
  logic       ctrl_end_txn;
  logic       ctrl_busy;
  logic [7:0] ctrl_data_out;

  logic       model_busy = 1'b0;
  logic       hold = 1'b0;
  int         cnt = 0;
  int         lat = 2;
  int         checks = 0;
  int         failures = 0;
  int         start_cnt = 0;
  int         viol = 0;
  logic       prev_start = 1'b0;
  logic [9:0] issued [$];

  always #5 clk = ~clk;

  assign ctrl_busy = model_busy | hold;

  spi_byte_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_dc          (wr_dc),
    .wr_end_txn     (wr_end_txn),
    .wr_capture     (wr_capture),
    .wr_ready       (wr_ready),
    .flush          (flush),
    .tx_level       (tx_level),
    .idle           (idle),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_pop         (rx_pop),
    .rx_overflow    (rx_overflow),
    .clear_overflow (clear_overflow),
    .ctrl_start     (ctrl_start),
    .ctrl_data      (ctrl_data),
    .ctrl_dc        (ctrl_dc),
    .ctrl_end_txn   (ctrl_end_txn),
    .ctrl_busy      (ctrl_busy),
    .ctrl_data_out  (ctrl_data_out)
  );

  always @(posedge clk) begin
    if (!rstn) begin
      model_busy <= 1'b0;
      cnt        <= 0;
    end else if (ctrl_start) begin
      model_busy <= 1'b1;
      cnt        <= lat;
    end else if (model_busy) begin
      if (cnt == 0) model_busy <= 1'b0;
      else          cnt <= cnt - 1;
    end
  end

  always @(posedge clk) begin
    prev_start <= ctrl_start;
    if (rstn && ctrl_start) begin
      start_cnt <= start_cnt + 1;
      issued.push_back({ctrl_end_txn, ctrl_dc, ctrl_data});
      if (prev_start) viol <= viol + 1;
      if (ctrl_busy)  viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic dc,
                      input logic e, input logic cap);
    wr_valid   = 1'b1;
    wr_data    = d;
    wr_dc      = dc;
    wr_end_txn = e;
    wr_capture = cap;
    tick();
    wr_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!ctrl_start && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("start_timeout", 0, 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_wr_ready"}, wr_ready, 1);
    check({p, "_tx_level"}, tx_level, 0);
    check({p, "_idle"}, idle, 1);
    check({p, "_start"}, ctrl_start, 0);
    check({p, "_data"}, ctrl_data, 0);
    check({p, "_dc"}, ctrl_dc, 0);
    check({p, "_end"}, ctrl_end_txn, 1);
    check({p, "_rx_valid"}, rx_valid, 0);
    check({p, "_ovf"}, rx_overflow, 0);
  endtask

  initial begin
    int s0;
    rstn = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    wr_dc = 1'b0;
    wr_end_txn = 1'b0;
    wr_capture = 1'b0;
    flush = 1'b0;
    rx_pop = 1'b0;
    clear_overflow = 1'b0;
    ctrl_data_out = 8'h00;
    tick();
    tick();
    check_reset("rst");
    rstn = 1'b1;
    tick();

    // single byte: start exactly two cycles after the push edge
    lat = 2;
    wr_valid = 1'b1;
    wr_data = 8'hA5;
    wr_dc = 1'b1;
    wr_end_txn = 1'b1;
    wr_capture = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("a_start_t1", ctrl_start, 0);
    check("a_level_t1", tx_level, 1);
    tick();
    check("a_start_t2", ctrl_start, 1);
    check("a_data", ctrl_data, 8'hA5);
    check("a_dc", ctrl_dc, 1);
    check("a_end", ctrl_end_txn, 1);
    tick();
    check("a_start_off", ctrl_start, 0);
    check("a_busy_idle", idle, 0);
    wait_idle();
    check("a_starts", start_cnt, 1);
    check("a_hold_data", ctrl_data, 8'hA5);

    // five pushes while controller busy, depth four
    issued.delete();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h10 + 8'(i);
      wr_dc = i[0];
      wr_end_txn = (i == 3);
      wr_capture = 1'b0;
      tick();
      if (i == 3) check("b_ready_low", wr_ready, 0);
    end
    wr_valid = 1'b0;
    check("b_level", tx_level, 4);
    check("b_ready", wr_ready, 0);
    hold = 1'b0;
    tick();
    wait_idle();
    check("b_count", issued.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("b_byte%0d", k),
            issued.size() > k ? int'(issued[k][7:0]) : -1, 'h10 + k);
    check("b_last_end", ctrl_end_txn, 1);

    // single capture, entry visible two cycles after busy drops
    ctrl_data_out = 8'h3C;
    push(8'h01, 1'b0, 1'b1, 1'b1);
    wait_idle();
    check("c_rx_b1", rx_valid, 0);
    tick();
    check("c_rx_b2", rx_valid, RX);
    check("c_rx_data", rx_data, RX ? 8'h3C : 8'h00);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    check("c_rx_popped", rx_valid, 0);

    // five captures into four-deep RX
    for (int i = 0; i < 5; i++) begin
      ctrl_data_out = 8'h50 + 8'(i);
      push(8'h60 + 8'(i), 1'b1, 1'b0, 1'b1);
      wait_idle();
    end
    tick();
    tick();
    check("d_ovf", rx_overflow, RX);
    check("d_rx_valid", rx_valid, RX);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("d_ovf_clr", rx_overflow, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d_rx%0d", k), rx_data, RX ? 'h50 + k : 0);
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    check("d_rx_empty", rx_valid, 0);

    // flush while first of three is in flight, with a colliding push
    lat = 4;
    s0 = start_cnt;
    hold = 1'b1;
    push(8'h21, 1'b0, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0, 1'b0);
    push(8'h23, 1'b0, 1'b1, 1'b0);
    hold = 1'b0;
    wait_start();
    tick();
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h99;
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    check("e_level", tx_level, 0);
    wait_idle();
    tick();
    tick();
    tick();
    check("e_starts", start_cnt - s0, 1);
    check("e_data", ctrl_data, 8'h21);

    // reset while busy: no capture lands, nothing reissued
    lat = 10;
    ctrl_data_out = 8'h77;
    s0 = start_cnt;
    push(8'h44, 1'b1, 1'b0, 1'b1);
    wait_start();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    check_reset("f");
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("f_no_rx", rx_valid, 0);
    check("f_starts", start_cnt - s0, 1);

    check("protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
